// File: rtl/axi_cache_bridge_pkg.sv
// Shared types and constants for the cache-to-AXI3 bridge: read request record,
// FSM state encodings, burst/ID defaults and the line-compare helper.
package axi_cache_bridge_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] ID_I_DEFAULT   = 4'd0;
    localparam logic [3:0] ID_D_DEFAULT   = 4'd1;

    typedef logic [1:0] rd_state_t;
    localparam rd_state_t R_IDLE = 2'd0;
    localparam rd_state_t R_AR   = 2'd1;
    localparam rd_state_t R_DATA = 2'd2;

    typedef logic [1:0] wr_state_t;
    localparam wr_state_t W_IDLE = 2'd0;
    localparam wr_state_t W_XFER = 2'd1;
    localparam wr_state_t W_RESP = 2'd2;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  len;
        logic [2:0]  size;
        logic [3:0]  id;
    } axi_rd_req_t;

    // Two byte addresses hit the same 16-byte line; callers pass addr[31:4].
    function automatic logic same_line(input logic [27:0] a, input logic [27:0] b);
        return (a == b);
    endfunction

endpackage

// File: rtl/axi_cache_bridge_write_channel.sv
// DCache write path: captures one writeback/uncached store, drives AW and W
// independently, then waits for the B response.
module axi_write_channel
    import axi_cache_bridge_pkg::*;
#(
    parameter int         LINE_WORDS = 4,
    parameter logic [3:0] ID_D       = ID_D_DEFAULT
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    d_wr_req,
    input  logic [31:0]             d_wr_addr,
    input  logic [1:0]              d_wr_len,
    input  logic [2:0]              d_wr_size,
    input  logic [3:0]              d_wr_strb,
    input  logic [32*LINE_WORDS-1:0] d_wr_data,
    output logic                    d_wr_ack,
    output logic                    d_wr_done,
    output logic [3:0]              awid,
    output logic [31:0]             awaddr,
    output logic [3:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [31:0]             wdata,
    output logic [3:0]              wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic                    bvalid,
    output logic                    bready,
    output logic                    wr_busy,
    output logic [27:0]             wr_line
);

    wr_state_t   state_r;
    logic [31:0] addr_r;
    logic [1:0]  len_r;
    logic [1:0]  beat_r;
    logic [2:0]  size_r;
    logic [3:0]  strb_r;
    logic [31:0] line_r [LINE_WORDS];
    logic        awvalid_r;
    logic        wvalid_r;
    logic        bready_r;
    logic        done_r;
    logic [3:0]  awid_r;
    logic [1:0]  awburst_r;

    logic accept_s;
    logic aw_fin_s;
    logic w_last_s;
    logic w_fin_s;

    assign accept_s = (state_r == W_IDLE) && d_wr_req;
    assign w_last_s = (beat_r == len_r);
    // A channel is finished when it was already idle or completes this cycle.
    assign aw_fin_s = !awvalid_r || awready;
    assign w_fin_s  = !wvalid_r || (wready && w_last_s);

    // Write FSM, line capture and beat counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r   <= W_IDLE;
            addr_r    <= 32'd0;
            len_r     <= 2'd0;
            beat_r    <= 2'd0;
            size_r    <= 3'd0;
            strb_r    <= 4'd0;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            bready_r  <= 1'b0;
            done_r    <= 1'b0;
            awid_r    <= 4'd0;
            awburst_r <= 2'd0;
            for (int k = 0; k < LINE_WORDS; k++) begin
                line_r[k] <= 32'd0;
            end
        end else begin
            done_r <= 1'b0;
            case (state_r)
                W_IDLE: begin
                    if (d_wr_req) begin
                        addr_r    <= d_wr_addr;
                        len_r     <= d_wr_len;
                        size_r    <= d_wr_size;
                        strb_r    <= d_wr_strb;
                        beat_r    <= 2'd0;
                        awid_r    <= ID_D;
                        awburst_r <= AXI_BURST_INCR;
                        awvalid_r <= 1'b1;
                        wvalid_r  <= 1'b1;
                        state_r   <= W_XFER;
                        for (int k = 0; k < LINE_WORDS; k++) begin
                            line_r[k] <= d_wr_data[k*32 +: 32];
                        end
                    end
                end
                W_XFER: begin
                    if (awvalid_r && awready) begin
                        awvalid_r <= 1'b0;
                    end
                    if (wvalid_r && wready) begin
                        if (w_last_s) begin
                            wvalid_r <= 1'b0;
                        end else begin
                            beat_r <= beat_r + 2'd1;
                        end
                    end
                    if (aw_fin_s && w_fin_s) begin
                        bready_r <= 1'b1;
                        state_r  <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (bvalid) begin
                        bready_r <= 1'b0;
                        done_r   <= 1'b1;
                        state_r  <= W_IDLE;
                    end
                end
                default: begin
                    state_r <= W_IDLE;
                end
            endcase
        end
    end

    // W beat data/strobe/last selected from the captured line.
    always_comb begin
        wdata = line_r[beat_r];
        wlast = wvalid_r && w_last_s;
        if (!wvalid_r) begin
            wstrb = 4'h0;
        end else if (len_r == 2'd0) begin
            wstrb = strb_r;
        end else begin
            wstrb = 4'hF;
        end
    end

    assign d_wr_ack  = accept_s;
    assign d_wr_done = done_r;
    assign awid      = awid_r;
    assign awaddr    = addr_r;
    assign awlen     = {2'b00, len_r};
    assign awsize    = size_r;
    assign awburst   = awburst_r;
    assign awvalid   = awvalid_r;
    assign wvalid    = wvalid_r;
    assign bready    = bready_r;
    assign wr_busy   = (state_r != W_IDLE);
    assign wr_line   = addr_r[31:4];

endmodule

// File: rtl/axi_cache_bridge.sv
// Merges ICache reads, DCache reads and DCache writes onto one AXI3 master,
// one read and one write outstanding, with read-after-write line hazard stall.
module axi_cache_bridge
    import axi_cache_bridge_pkg::*;
#(
    parameter int         LINE_WORDS = 4,
    parameter logic [3:0] ID_I       = ID_I_DEFAULT,
    parameter logic [3:0] ID_D       = ID_D_DEFAULT
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     i_rd_req,
    input  logic [31:0]              i_rd_addr,
    input  logic [1:0]               i_rd_len,
    output logic                     i_rd_ack,
    output logic                     i_rd_valid,
    output logic [31:0]              i_rd_data,
    output logic                     i_rd_last,
    input  logic                     d_rd_req,
    input  logic [31:0]              d_rd_addr,
    input  logic [1:0]               d_rd_len,
    input  logic [2:0]               d_rd_size,
    output logic                     d_rd_ack,
    output logic                     d_rd_valid,
    output logic [31:0]              d_rd_data,
    output logic                     d_rd_last,
    input  logic                     d_wr_req,
    input  logic [31:0]              d_wr_addr,
    input  logic [1:0]               d_wr_len,
    input  logic [2:0]               d_wr_size,
    input  logic [3:0]               d_wr_strb,
    input  logic [32*LINE_WORDS-1:0] d_wr_data,
    output logic                     d_wr_ack,
    output logic                     d_wr_done,
    output logic [3:0]               arid,
    output logic [31:0]              araddr,
    output logic [3:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [3:0]               rid,
    input  logic [31:0]              rdata,
    input  logic                     rlast,
    input  logic                     rvalid,
    output logic                     rready,
    output logic [3:0]               awid,
    output logic [31:0]              awaddr,
    output logic [3:0]               awlen,
    output logic [2:0]               awsize,
    output logic [1:0]               awburst,
    output logic                     awvalid,
    input  logic                     awready,
    output logic [31:0]              wdata,
    output logic [3:0]               wstrb,
    output logic                     wlast,
    output logic                     wvalid,
    input  logic                     wready,
    input  logic                     bvalid,
    output logic                     bready
);

    rd_state_t   rd_state_r;
    axi_rd_req_t rd_req_r;
    logic        arvalid_r;
    logic        rready_r;
    logic        grant_d_r;
    logic [1:0]  arburst_r;

    logic        wr_busy_s;
    logic [27:0] wr_line_s;
    logic        i_haz_s;
    logic        d_haz_s;
    logic        grant_d_s;
    logic        grant_i_s;
    logic        ar_hs_s;
    logic        beat_s;

    axi_write_channel #(
        .LINE_WORDS (LINE_WORDS),
        .ID_D       (ID_D)
    ) u_write (
        .clk       (clk),
        .resetn    (resetn),
        .d_wr_req  (d_wr_req),
        .d_wr_addr (d_wr_addr),
        .d_wr_len  (d_wr_len),
        .d_wr_size (d_wr_size),
        .d_wr_strb (d_wr_strb),
        .d_wr_data (d_wr_data),
        .d_wr_ack  (d_wr_ack),
        .d_wr_done (d_wr_done),
        .awid      (awid),
        .awaddr    (awaddr),
        .awlen     (awlen),
        .awsize    (awsize),
        .awburst   (awburst),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wlast     (wlast),
        .wvalid    (wvalid),
        .wready    (wready),
        .bvalid    (bvalid),
        .bready    (bready),
        .wr_busy   (wr_busy_s),
        .wr_line   (wr_line_s)
    );

    // Hazard covers both a pending write and one being accepted this very cycle.
    always_comb begin
        i_haz_s = (wr_busy_s && same_line(i_rd_addr[31:4], wr_line_s)) ||
                  (!wr_busy_s && d_wr_req && same_line(i_rd_addr[31:4], d_wr_addr[31:4]));
        d_haz_s = (wr_busy_s && same_line(d_rd_addr[31:4], wr_line_s)) ||
                  (!wr_busy_s && d_wr_req && same_line(d_rd_addr[31:4], d_wr_addr[31:4]));
        grant_d_s = d_rd_req && !d_haz_s;
        grant_i_s = i_rd_req && !i_haz_s && !grant_d_s;
        ar_hs_s   = arvalid_r && arready;
        beat_s    = rready_r && rvalid;
    end

    // Read arbiter and AR/R sequencing.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_state_r <= R_IDLE;
            rd_req_r   <= '0;
            arvalid_r  <= 1'b0;
            rready_r   <= 1'b0;
            grant_d_r  <= 1'b0;
            arburst_r  <= 2'b00;
        end else begin
            case (rd_state_r)
                R_IDLE: begin
                    if (grant_d_s) begin
                        rd_req_r   <= '{addr: d_rd_addr, len: d_rd_len, size: d_rd_size, id: ID_D};
                        grant_d_r  <= 1'b1;
                        arvalid_r  <= 1'b1;
                        arburst_r  <= AXI_BURST_INCR;
                        rd_state_r <= R_AR;
                    end else if (grant_i_s) begin
                        rd_req_r   <= '{addr: i_rd_addr, len: i_rd_len, size: 3'd2, id: ID_I};
                        grant_d_r  <= 1'b0;
                        arvalid_r  <= 1'b1;
                        arburst_r  <= AXI_BURST_INCR;
                        rd_state_r <= R_AR;
                    end
                end
                R_AR: begin
                    if (ar_hs_s) begin
                        arvalid_r  <= 1'b0;
                        rready_r   <= 1'b1;
                        rd_state_r <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rvalid && rlast) begin
                        rready_r   <= 1'b0;
                        rd_state_r <= R_IDLE;
                    end
                end
                default: begin
                    rd_state_r <= R_IDLE;
                end
            endcase
        end
    end

    // Acks follow the AR handshake; R beats are steered by rid.
    always_comb begin
        i_rd_ack   = ar_hs_s && !grant_d_r;
        d_rd_ack   = ar_hs_s && grant_d_r;
        i_rd_valid = beat_s && (rid == ID_I);
        d_rd_valid = beat_s && (rid == ID_D);
        i_rd_last  = i_rd_valid && rlast;
        d_rd_last  = d_rd_valid && rlast;
        i_rd_data  = rdata;
        d_rd_data  = rdata;
    end

    assign arid    = rd_req_r.id;
    assign araddr  = rd_req_r.addr;
    assign arlen   = {2'b00, rd_req_r.len};
    assign arsize  = rd_req_r.size;
    assign arburst = arburst_r;
    assign arvalid = arvalid_r;
    assign rready  = rready_r;

endmodule

// File: tb/tb_axi_cache_bridge.sv
// Scoreboard bench for axi_cache_bridge: directed stimulus pushes expected
// AR/AW/W/R events into queues; a negedge monitor pops and compares them.
module tb_axi_cache_bridge;
    import axi_cache_bridge_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    logic i_rd_req = 1'b0, d_rd_req = 1'b0, d_wr_req = 1'b0;
    logic [31:0] i_rd_addr = 32'd0, d_rd_addr = 32'd0, d_wr_addr = 32'd0;
    logic [1:0] i_rd_len = 2'd0, d_rd_len = 2'd0, d_wr_len = 2'd0;
    logic [2:0] d_rd_size = 3'd0, d_wr_size = 3'd0;
    logic [3:0] d_wr_strb = 4'd0;
    logic [127:0] d_wr_data = 128'd0;
    logic i_rd_ack, i_rd_valid, i_rd_last, d_rd_ack, d_rd_valid, d_rd_last;
    logic [31:0] i_rd_data, d_rd_data;
    logic d_wr_ack, d_wr_done;
    logic [3:0] arid, awid, arlen, awlen;
    logic [31:0] araddr, awaddr, wdata;
    logic [2:0] arsize, awsize;
    logic [1:0] arburst, awburst;
    logic arvalid, rready, awvalid, wlast, wvalid, bready;
    logic [3:0] wstrb;
    logic arready = 1'b1, awready = 1'b1, wready = 1'b1, bvalid = 1'b0;
    logic [3:0] rid = 4'd0;
    logic [31:0] rdata = 32'd0;
    logic rlast = 1'b0, rvalid = 1'b0;

    always #5 clk = ~clk;

    axi_cache_bridge dut (
        .clk(clk), .resetn(resetn),
        .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .i_rd_len(i_rd_len), .i_rd_ack(i_rd_ack),
        .i_rd_valid(i_rd_valid), .i_rd_data(i_rd_data), .i_rd_last(i_rd_last),
        .d_rd_req(d_rd_req), .d_rd_addr(d_rd_addr), .d_rd_len(d_rd_len), .d_rd_size(d_rd_size),
        .d_rd_ack(d_rd_ack), .d_rd_valid(d_rd_valid), .d_rd_data(d_rd_data), .d_rd_last(d_rd_last),
        .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_len(d_wr_len), .d_wr_size(d_wr_size),
        .d_wr_strb(d_wr_strb), .d_wr_data(d_wr_data), .d_wr_ack(d_wr_ack), .d_wr_done(d_wr_done),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
    } addr_exp_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } beat_exp_t;

    addr_exp_t ar_q[$];
    addr_exp_t aw_q[$];
    beat_exp_t i_q[$];
    beat_exp_t d_q[$];
    beat_exp_t w_q[$];

    int checks = 0;
    int errors = 0;
    int i_ack_cnt = 0, d_ack_cnt = 0, wr_ack_cnt = 0, done_cnt = 0;

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    function automatic void unexpected(input string name, input logic [127:0] act);
        checks++;
        errors++;
        $display("FAIL %s actual=%0h expected=no_event", name, act);
    endfunction

    // Monitor: compare every presented event with the head of its queue.
    always @(negedge clk) begin : monitor
        addr_exp_t ea;
        beat_exp_t eb;
        if (resetn) begin
            if (i_rd_ack) i_ack_cnt++;
            if (d_rd_ack) d_ack_cnt++;
            if (d_wr_ack) wr_ack_cnt++;
            if (d_wr_done) done_cnt++;
            if (arvalid && arready) begin
                if (ar_q.size() == 0) unexpected("ar", {arid, araddr});
                else begin
                    ea = ar_q.pop_front();
                    check("ar", {arid, araddr, arlen, arsize, arburst}, {ea.id, ea.addr, ea.len, ea.size, AXI_BURST_INCR});
                end
            end
            if (awvalid && awready) begin
                if (aw_q.size() == 0) unexpected("aw", {awid, awaddr});
                else begin
                    ea = aw_q.pop_front();
                    check("aw", {awid, awaddr, awlen, awsize, awburst}, {ea.id, ea.addr, ea.len, ea.size, AXI_BURST_INCR});
                end
            end
            if (wvalid && wready) begin
                if (w_q.size() == 0) unexpected("w", wdata);
                else begin
                    eb = w_q.pop_front();
                    check("w", {wdata, wstrb, wlast}, {eb.data, eb.strb, eb.last});
                end
            end
            if (i_rd_valid) begin
                if (i_q.size() == 0) unexpected("i_rd", i_rd_data);
                else begin
                    eb = i_q.pop_front();
                    check("i_rd", {i_rd_data, i_rd_last}, {eb.data, eb.last});
                end
            end
            if (d_rd_valid) begin
                if (d_q.size() == 0) unexpected("d_rd", d_rd_data);
                else begin
                    eb = d_q.pop_front();
                    check("d_rd", {d_rd_data, d_rd_last}, {eb.data, eb.last});
                end
            end
        end
    end

    function automatic void push_rd(input bit is_d, input logic [31:0] addr, input logic [1:0] len,
                                    input logic [2:0] size, input logic [31:0] first, input int nbeats);
        ar_q.push_back('{is_d ? 4'd1 : 4'd0, addr, {2'b00, len}, size});
        for (int k = 0; k < nbeats; k++) begin
            if (is_d) d_q.push_back('{first + k, 4'h0, (k == nbeats - 1)});
            else      i_q.push_back('{first + k, 4'h0, (k == nbeats - 1)});
        end
    endfunction

    function automatic void check_idle(input string tag);
        check({tag, "_ctrl"}, {i_rd_ack, i_rd_valid, i_rd_last, d_rd_ack, d_rd_valid, d_rd_last,
                               d_wr_ack, d_wr_done, arvalid, rready, awvalid, wvalid, wlast, bready}, 128'd0);
        check({tag, "_ar"}, {arid, araddr, arlen, arsize, arburst}, 128'd0);
        check({tag, "_aw"}, {awid, awaddr, awlen, awsize, awburst, wstrb}, 128'd0);
        check({tag, "_wdata"}, wdata, 128'd0);
    endfunction

    task automatic wait_rd_ack(input bit is_d, output int lat);
        bit got = 1'b0;
        lat = 0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            got = is_d ? d_rd_ack : i_rd_ack;
        end
        check(is_d ? "d_rd_ack_seen" : "i_rd_ack_seen", got, 1);
    endtask

    task automatic do_read(input bit is_d, input logic [31:0] first, input int nbeats, output int lat);
        wait_rd_ack(is_d, lat);
        @(posedge clk); #1;
        if (is_d) d_rd_req = 1'b0;
        else      i_rd_req = 1'b0;
        for (int k = 0; k < nbeats; k++) begin
            rvalid = 1'b1;
            rid    = is_d ? 4'd1 : 4'd0;
            rdata  = first + k;
            rlast  = (k == nbeats - 1);
            @(posedge clk); #1;
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    task automatic finish_b();
        int  n = 0;
        bit  got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            got = bready;
        end
        check("bready_seen", got, 1);
        @(posedge clk); #1;
        bvalid = 1'b1;
        @(posedge clk); #1;
        bvalid = 1'b0;
        @(negedge clk);
        check("wr_done", d_wr_done, 1);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [1:0] len, input logic [2:0] size,
                            input logic [3:0] strb, input logic [127:0] data, input int aw_delay, input bit hold_b);
        int n = 0;
        bit got = 1'b0;
        awready   = (aw_delay == 0);
        d_wr_addr = addr;
        d_wr_len  = len;
        d_wr_size = size;
        d_wr_strb = strb;
        d_wr_data = data;
        d_wr_req  = 1'b1;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            got = d_wr_ack;
        end
        check("wr_ack_seen", got, 1);
        check("wr_ack_latency", n, 1);
        @(posedge clk); #1;
        d_wr_req = 1'b0;
        if (aw_delay > 0) begin
            repeat (aw_delay) @(posedge clk);
            #1;
            awready = 1'b1;
        end
        if (!hold_b) finish_b();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int lat;
        int blocked;
        #2 resetn = 1'b0;
        #10 check_idle("reset");
        @(posedge clk); #1 resetn = 1'b1;

        // 1: ICache line read
        @(posedge clk); #1;
        push_rd(1'b0, 32'h1FC0_0000, 2'd3, 3'd2, 32'hA0, 4);
        i_rd_addr = 32'h1FC0_0000; i_rd_len = 2'd3; i_rd_req = 1'b1;
        do_read(1'b0, 32'hA0, 4, lat);
        check("t1_ack_latency", lat, 2);

        // 2: simultaneous requests, D wins, I follows right after D's rlast
        @(posedge clk); #1;
        push_rd(1'b1, 32'h0000_1000, 2'd3, 3'd2, 32'hD0, 4);
        push_rd(1'b0, 32'h1FC0_0010, 2'd0, 3'd2, 32'hE0, 1);
        d_rd_addr = 32'h0000_1000; d_rd_len = 2'd3; d_rd_size = 3'd2; d_rd_req = 1'b1;
        i_rd_addr = 32'h1FC0_0010; i_rd_len = 2'd0; i_rd_req = 1'b1;
        do_read(1'b1, 32'hD0, 4, lat);
        check("t2_d_latency", lat, 2);
        do_read(1'b0, 32'hE0, 1, lat);
        check("t2_i_latency", lat, 2);

        // 3: line writeback with late awready
        @(posedge clk); #1;
        aw_q.push_back('{4'd1, 32'h0000_0100, 4'd3, 3'd2});
        w_q.push_back('{32'h11, 4'hF, 1'b0});
        w_q.push_back('{32'h22, 4'hF, 1'b0});
        w_q.push_back('{32'h33, 4'hF, 1'b0});
        w_q.push_back('{32'h44, 4'hF, 1'b1});
        do_write(32'h0000_0100, 2'd3, 3'd2, 4'hF, {32'h44, 32'h33, 32'h22, 32'h11}, 3, 1'b0);

        // 4: uncached byte store
        @(posedge clk); #1;
        aw_q.push_back('{4'd1, 32'hBFAF_F000, 4'd0, 3'd0});
        w_q.push_back('{32'h0000_AB00, 4'b0010, 1'b1});
        do_write(32'hBFAF_F000, 2'd0, 3'd0, 4'b0010, {96'd0, 32'h0000_AB00}, 0, 1'b0);

        // 5: read hazard on the pending write's line; other line proceeds
        @(posedge clk); #1;
        aw_q.push_back('{4'd1, 32'h0000_0100, 4'd0, 3'd2});
        w_q.push_back('{32'h5555_AAAA, 4'hF, 1'b1});
        do_write(32'h0000_0100, 2'd0, 3'd2, 4'hF, {96'd0, 32'h5555_AAAA}, 0, 1'b1);
        push_rd(1'b0, 32'h0000_0200, 2'd0, 3'd2, 32'h77, 1);
        d_rd_addr = 32'h0000_0104; d_rd_len = 2'd0; d_rd_size = 3'd2; d_rd_req = 1'b1;
        i_rd_addr = 32'h0000_0200; i_rd_len = 2'd0; i_rd_req = 1'b1;
        do_read(1'b0, 32'h77, 1, lat);
        blocked = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (arvalid) blocked++;
        end
        check("t5_ar_blocked", blocked, 0);
        check("t5_bready_held", bready, 1);
        push_rd(1'b1, 32'h0000_0104, 2'd0, 3'd2, 32'h66, 1);
        finish_b();
        do_read(1'b1, 32'h66, 1, lat);

        // 6: reset during beat 2 of a D line read, then a clean I read
        @(posedge clk); #1;
        ar_q.push_back('{4'd1, 32'h2000_0040, 4'd3, 3'd2});
        d_q.push_back('{32'hD0, 4'h0, 1'b0});
        d_q.push_back('{32'hD1, 4'h0, 1'b0});
        d_rd_addr = 32'h2000_0040; d_rd_len = 2'd3; d_rd_size = 3'd2; d_rd_req = 1'b1;
        wait_rd_ack(1'b1, lat);
        @(posedge clk); #1;
        d_rd_req = 1'b0;
        rvalid = 1'b1; rid = 4'd1; rlast = 1'b0; rdata = 32'hD0;
        @(posedge clk); #1 rdata = 32'hD1;
        @(posedge clk); #1 rdata = 32'hD2;
        #2 resetn = 1'b0;
        #1 check_idle("t6_abort");
        rvalid = 1'b0;
        @(posedge clk); #1 resetn = 1'b1;
        @(posedge clk); #1;
        push_rd(1'b0, 32'h1FC0_0040, 2'd3, 3'd2, 32'hB0, 4);
        i_rd_addr = 32'h1FC0_0040; i_rd_len = 2'd3; i_rd_req = 1'b1;
        do_read(1'b0, 32'hB0, 4, lat);
        check("t6_i_latency", lat, 2);

        repeat (3) @(posedge clk);
        #1;
        check("ar_q_left", ar_q.size(), 0);
        check("aw_q_left", aw_q.size(), 0);
        check("w_q_left", w_q.size(), 0);
        check("i_q_left", i_q.size(), 0);
        check("d_q_left", d_q.size(), 0);
        check("i_ack_count", i_ack_cnt, 4);
        check("d_ack_count", d_ack_cnt, 3);
        check("wr_ack_count", wr_ack_cnt, 3);
        check("wr_done_count", done_cnt, 3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_cache_bridge.md
Name: axi_cache_bridge

Overview:
Sits directly downstream of the ICache/DCache pair fed by the CPU core's IBus/DBus. Merges three miss-side requesters onto one AXI3 master port: ICache refill/uncached fetch reads, DCache refill/uncached load reads, and DCache dirty-line writeback/uncached store writes. Allows one outstanding read and one outstanding write. Stalls any read that overlaps a pending write.

Parameters:
LINE_WORDS, 4, words per cache line; also the maximum burst length.
ID_I, 4'd0, ARID used for ICache reads.
ID_D, 4'd1, ARID/AWID used for DCache reads and writes.

Ports:
clk  in  1  clock
resetn  in  1  reset; asynchronous, active-low
i_rd_req  in  1  ICache read request; held until i_rd_ack
i_rd_addr  in  32  physical byte address; line-aligned if len>0
i_rd_len  in  2  beats-1 (0 = uncached single, 3 = line)
i_rd_ack  out  1  1-cycle pulse: request accepted on AR
i_rd_valid  out  1  beat valid
i_rd_data  out  32  beat data
i_rd_last  out  1  final beat
d_rd_req/d_rd_addr/d_rd_len/d_rd_ack/d_rd_valid/d_rd_data/d_rd_last  same as i_*, for DCache
d_rd_size  in  3  AXI size for uncached loads (2 for line reads)
d_wr_req  in  1  DCache write request; held until d_wr_ack
d_wr_addr  in  32  physical address
d_wr_len  in  2  beats-1
d_wr_size  in  3  AXI size
d_wr_strb  in  4  byte strobe for single-beat writes (line writes use 4'hF)
d_wr_data  in  32*LINE_WORDS  line data; word k sent on beat k
d_wr_ack  out  1  pulse: data captured; requester may change inputs
d_wr_done  out  1  pulse on B handshake
arid/araddr/arlen/arsize/arburst/arvalid  out  4/32/4/3/2/1  AXI AR
arready  in  1
rid/rdata/rlast/rvalid  in  4/32/1/1; rready out 1
awid/awaddr/awlen/awsize/awburst/awvalid  out  4/32/4/3/2/1; awready in 1
wdata/wstrb/wlast/wvalid  out  32/4/1/1; wready in 1
bvalid  in  1; bready out 1

Behaviour:
- Reset (resetn low, async): both FSMs idle. All valid/ack/done outputs 0, rready=0, bready=0, AXI address/data outputs 0.
- Read FSM states: R_IDLE -> R_AR -> R_DATA -> R_IDLE.
- R_IDLE arbitration: fixed priority, D over I. The winner's addr/len/size/id are latched. Moves to R_AR next cycle, with arvalid=1 and the registered fields.
- Read hazard: a request is not granted while the write FSM is non-idle and addr[31:4] equals the latched write addr[31:4]. Such a request waits in R_IDLE; the other requester may still be granted.
- R_AR: stays until arvalid&&arready. That cycle pulses the winner's *_rd_ack, drops arvalid and moves to R_DATA. arburst is INCR (2'b01); arlen={2'b0,len}. I reads use arsize 2.
- R_DATA: rready=1. Each rvalid beat is routed combinationally by rid to {i,d}_rd_valid/data/last; rdata and rlast pass through. rlast&&rvalid returns to R_IDLE. A new grant is possible in the following cycle.
- Write FSM states: W_IDLE -> W_XFER -> W_RESP -> W_IDLE.
- W_IDLE: on d_wr_req, captures addr/len/size/strb/data into registers, pulses d_wr_ack in the same cycle, and enters W_XFER with awvalid=1 and wvalid=1.
- W_XFER: AW and W are independent. awvalid drops after its handshake. The W beat counter (2 bits) advances on each wvalid&&wready. wdata = captured word[beat]; wlast = (beat==len); wstrb = len==0 ? strb : 4'hF. The last W handshake drops wvalid.
- W_XFER exit: moves to W_RESP once both AW and last W are done, in either order or the same cycle.
- W_RESP: bready=1. On bvalid, pulses d_wr_done and returns to W_IDLE.
- Simultaneous events: read and write FSMs run concurrently. A d_wr_req and d_rd_req in the same cycle to the same line are resolved write-first: the write latch wins and the read waits for d_wr_done.
- Response codes (rresp/bresp) are not checked.
- resetn asserted mid-burst: FSMs abort immediately to idle. The interconnect is reset by the same signal.

Decomposition:
- Shared package gets typedef axi_rd_req_t {addr,len,size,id}, the FSM state enums, and constants AXI_BURST_INCR and ID_I/ID_D defaults.
- One natural sub-module: axi_write_channel, containing the write FSM, line register and beat counter. The read arbiter/FSM stays in the top.

Test Plan:
1. I line read 0x1FC0_0000, arready=1, rdata 0xA0..0xA3: arlen=3, arid=0, i_rd_ack 1 cycle, four i_rd_valid beats with i_rd_last on 0xA3, d_rd_valid never set.
2. I and D requests in the same cycle: D is granted first (arid=1, araddr=D addr). I is granted the cycle after D's rlast.
3. D line writeback to 0x0000_0100, data words 0x11..0x44, with awready delayed 3 cycles and wready=1: wdata 0x11,0x22,0x33,0x44, wlast on 0x44, awlen=3, then bready, and d_wr_done 1 cycle after bvalid.
4. Uncached store to 0xBFAF_F000, len=0, strb 4'b0010, size 0: one W beat with wstrb=4'b0010, wlast=1.
5. Write to 0x100 pending with bvalid withheld, then d_rd_req to 0x104: arvalid stays 0 until d_wr_done. A concurrent i_rd_req to 0x200 is granted meanwhile.
6. resetn pulled low during beat 2 of a D read: all outputs return to 0 asynchronously. After release, a new I read completes normally.
